// File: rtl/data_memory_pkg.sv
// Shared encodings and small decode helpers for the sized data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // The reserved size code is always reported as misaligned.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input size_e size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_sized_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_extend
  import data_memory_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_sel = word_in[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    half_sel  = addr_lo[1] ? word_in[31:16] : word_in[15:0];
    byte_sign = ~is_unsigned & byte_sel[7];
    half_sign = ~is_unsigned & half_sel[15];

    data_out = '0;
    case (size)
      SIZE_BYTE: data_out = {{24{byte_sign}}, byte_sel};
      SIZE_HALF: data_out = {{16{half_sign}}, half_sel};
      SIZE_WORD: data_out = word_in;
      default:   data_out = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// M-stage data memory: init sequencer, byte-lane stores, registered loads
// with extension, and a one-cycle response carrying alignment/range errors.
module data_memory_sized
  import data_memory_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int INIT_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        rsp_valid,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rd_word_q, rd_word_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            mis_q, mis_d;
  logic            oor_q, oor_d;
  logic            load_ok_q, load_ok_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;

  size_e           req_size_e;
  logic            accept;
  logic            align_err;
  logic            range_err;
  logic            req_err;
  logic            rd_en;
  logic [AW-1:0]   req_idx;
  logic [31:0]     init_pattern;

  logic [3:0]      wr_be;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic [31:0]     ext_data;

  assign ready      = (state_q == ST_RUN);
  assign req_size_e = size_e'(req_size);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_WORD) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Any index bit above the array width makes the request out of range.
  always_comb begin
    accept    = req_valid && ready;
    req_idx   = address[AW+1:2];
    range_err = |address[31:AW+2];
    align_err = is_misaligned(req_size_e, address[1:0]);
    req_err   = range_err || align_err;
    rd_en     = accept && !req_write && !req_err;
  end

  assign init_pattern = (INIT_MODE == INIT_INDEX) ? 32'(init_cnt_q) : 32'd0;

  always_comb begin
    wr_be   = '0;
    wr_idx  = init_cnt_q;
    wr_data = init_pattern;
    if (state_q == ST_INIT) begin
      wr_be = 4'b1111;
    end else if (accept && req_write && !req_err) begin
      wr_be   = lane_mask(req_size_e, address[1:0]);
      wr_idx  = req_idx;
      wr_data = replicate(req_size_e, write_data);
    end
  end

  assign rd_word_d = rd_en ? mem_q[req_idx] : rd_word_q;

  // Array is not reset; the init sequencer overwrites every word after reset.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (wr_be[lane]) begin
        mem_q[wr_idx][8*lane +: 8] <= wr_data[8*lane +: 8];
      end
    end
    rd_word_q <= rd_word_d;
  end

  always_comb begin
    rsp_valid_d = accept;
    mis_d       = accept && align_err;
    oor_d       = accept && range_err;
    load_ok_d   = rd_en;
    addr_lo_d   = accept ? address[1:0] : addr_lo_q;
    size_d      = accept ? req_size_e : size_q;
    uns_d       = accept ? req_unsigned : uns_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
      load_ok_q   <= 1'b0;
      addr_lo_q   <= '0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      mis_q       <= mis_d;
      oor_q       <= oor_d;
      load_ok_q   <= load_ok_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  mem_load_extend u_load_extend (
    .word_in     (rd_word_q),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data_out    (ext_data)
  );

  assign rsp_valid    = rsp_valid_q;
  assign misaligned   = mis_q;
  assign out_of_range = oor_q;
  assign read_data    = load_ok_q ? ext_data : 32'd0;

endmodule
